via6522_lite: RTL and testbench
===============================

VIA6522_LITE -- requirements
Module: via6522_lite

Interface
REQ-001 clk  input  1  CPU clock (1 MHz enable domain, same clock as the PIA registers); all state updates on rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-003 cs  input  1  chip select (address 0xB8xx decode).
REQ-004 rnw  input  1  1=read, 0=write (registered CPU rnw).
REQ-005 addr  input  4  register select RS[3:0].
REQ-006 din  input  8  write data.
REQ-007 dout  output  8  read data, combinational from addr and current state.
REQ-008 irq_n  output  1  active-low interrupt request.
REQ-009 pa_in, pb_in  input  8 each  port pin levels.
REQ-010 pa_out, pb_out  output  8 each  ORA/ORB values.
REQ-011 pa_oe, pb_oe  output  8 each  equal to DDRA/DDRB (1=output).
REQ-012 ca1, cb1  input  1 each  asynchronous edge inputs.

Function
REQ-013 Register map: 0 ORB/IRB, 1 ORA/IRA, 2 DDRB, 3 DDRA, 4 T1C-L, 5 T1C-H, 6 T1L-L, 7 T1L-H, 8 T2C-L, 9 T2C-H, A SR (reads 0x00, writes ignored), B ACR, C PCR, D IFR, E IER, F ORA (no flag clear).
REQ-014 Writes: take effect on the rising clk where cs=1 and rnw=0; reads have no side effects unless stated.
REQ-015 IRB read = (ORB & DDRB) | (pb_in & ~DDRB); IRA read = pa_in.
REQ-016 ca1/cb1: two-flop synchroniser, then edge detect; PCR[0]/PCR[4]: 0=falling, 1=rising; edge sets IFR[1]/IFR[4].
REQ-017 IFR[1] cleared by read or write of reg 1; IFR[4] cleared by read or write of reg 0.
REQ-018 T1: 16-bit counter decrements every clk while not being loaded; wraps 0x0000 -> 0xFFFF.
REQ-019 Write reg 4 or 6 -> T1L-L; write reg 7 -> T1L-H, clears IFR[6]; write reg 5 -> T1L-H, counter := {din, T1L-L}, clears IFR[6], arms T1.
REQ-020 T1 timeout: rising clk where counter = 0x0000 and T1 armed; sets IFR[6] (period = N+1 clks after load).
REQ-021 ACR[6]=0 one-shot: disarm on timeout, counter keeps decrementing, no further flags until reg 5 rewritten; ACR[6]=1 free-run: counter := latch on timeout (period N+2), stays armed.
REQ-022 Read reg 4 returns counter[7:0] and clears IFR[6]; reg 5 counter[15:8]; reg 6/7 latch bytes.
REQ-023 T2 (one-shot only, ACR[5] ignored): write reg 8 -> T2L-L; write reg 9 -> counter := {din, T2L-L}, clears IFR[5], arms; timeout at counter = 0 sets IFR[5], disarms, counter keeps decrementing; read reg 8 clears IFR[5].
REQ-024 IFR write: each din bit =1 clears the matching IFR[6:0] bit; IFR[7] read = |(IFR[6:0] & IER[6:0]).
REQ-025 IER write: din[7]=1 sets, din[7]=0 clears the IER[6:0] bits where din=1; IER read returns {1'b1, IER[6:0]}.
REQ-026 irq_n = ~IFR[7], combinational from registered flags.
REQ-027 Simultaneous set and clear of one IFR bit in one cycle: set wins, except load by reg 5/9 write in the timeout cycle: load wins, flag cleared.
REQ-028 Unused IFR bits 0, 2, 3 read 0.

Reset
REQ-029 reset_n=0 at rising clk: ORA, ORB, DDRA, DDRB, ACR, PCR, IFR, IER := 0; T1/T2 counters and latches := 0; T1/T2 disarmed; synchronisers := 0.
REQ-030 During and after reset: irq_n=1, pa_oe=pb_oe=0x00, pa_out=pb_out=0x00; reset mid-count aborts the timer with no flag raised.

Configuration
REQ-031 Macro VIA_TIMER2_EN: defined -> T2 as REQ-023; undefined -> regs 8/9 read 0x00, writes ignored, IFR[5] always 0, T2 logic absent.

Verification
REQ-032 Write DDRB=0x0F, ORB=0xA5, pb_in=0x3C -> read reg 0 = 0x35; pb_oe=0x0F.
REQ-033 IER write 0xC0, ACR=0x00, reg 4=0x05, reg 5=0x00 -> irq_n falls exactly 6 clks after the reg 5 write clk; read reg 4 -> irq_n=1; no second irq within 70000 clks.
REQ-034 ACR=0x40, T1 load 0x0003 -> IFR[6] set every 5 clks; IFR write 0x40 clears each occurrence.
REQ-035 PCR=0x01, IER=0x82, ca1 rising pulse -> IFR read 0x82 within 3 clks, irq_n=0; read reg 1 -> IFR=0x00; falling ca1 edge sets nothing.
REQ-036 T2 load 0x0010 with VIA_TIMER2_EN -> IFR[5] after 17 clks; without macro -> IFR[5] stays 0, reg 8 reads 0x00.
REQ-037 reset_n=0 mid T1 countdown with IER[6]=1 -> irq_n stays 1, all registers read 0 (IER reads 0x80).

Source files
------------

// File: rtl/via6522_lite_if.sv
// CPU-side bus of the via6522_lite: chip select, direction, register select,
// data in both directions and the interrupt request.
`timescale 1ns/1ps

interface via6522_lite_if;
    logic       cs;
    logic       rnw;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq_n;

    modport master (output cs, rnw, addr, din, input dout, irq_n);
    modport slave  (input cs, rnw, addr, din, output dout, irq_n);
endinterface

// File: rtl/via6522_lite.sv
// Reduced 6522 VIA: two 8-bit ports, CA1/CB1 edge flags, T1 one-shot/free-run
// and optional T2 one-shot timer (present only when VIA_TIMER2_EN is defined).
`timescale 1ns/1ps

module via6522_lite (
    input  logic          clk,
    input  logic          reset_n,
    via6522_lite_if.slave bus,
    input  logic [7:0]    pa_in,
    input  logic [7:0]    pb_in,
    output logic [7:0]    pa_out,
    output logic [7:0]    pb_out,
    output logic [7:0]    pa_oe,
    output logic [7:0]    pb_oe,
    input  logic          ca1,
    input  logic          cb1
);

    typedef enum logic [3:0] {
        REG_ORB  = 4'h0, REG_ORA  = 4'h1, REG_DDRB = 4'h2, REG_DDRA = 4'h3,
        REG_T1CL = 4'h4, REG_T1CH = 4'h5, REG_T1LL = 4'h6, REG_T1LH = 4'h7,
        REG_T2CL = 4'h8, REG_T2CH = 4'h9, REG_SR   = 4'hA, REG_ACR  = 4'hB,
        REG_PCR  = 4'hC, REG_IFR  = 4'hD, REG_IER  = 4'hE, REG_ORA_NH = 4'hF
    } reg_e;

    reg_e        reg_sel;
    logic        wr, rd;

    logic [7:0]  ora_q, ora_d, orb_q, orb_d;
    logic [7:0]  ddra_q, ddra_d, ddrb_q, ddrb_d;
    logic [7:0]  acr_q, acr_d, pcr_q, pcr_d;
    logic [6:0]  ifr_q, ifr_d, ier_q, ier_d;
    logic [6:0]  ifr_set, ifr_clr;
    logic [2:0]  ca_sync_q, ca_sync_d, cb_sync_q, cb_sync_d;
    logic        ca_edge, cb_edge;

    logic [15:0] t1_cnt_q, t1_cnt_d, t1_lat_q, t1_lat_d;
    logic        t1_armed_q, t1_armed_d, t1_reload_q, t1_reload_d;
    logic        t1_load, t1_timeout;

`ifdef VIA_TIMER2_EN
    logic [15:0] t2_cnt_q, t2_cnt_d;
    logic [7:0]  t2_lat_q, t2_lat_d;
    logic        t2_armed_q, t2_armed_d;
    logic        t2_load, t2_timeout;
`endif

    assign reg_sel = reg_e'(bus.addr);
    assign wr      = bus.cs & ~bus.rnw;
    assign rd      = bus.cs & bus.rnw;

    // sync bit1 is the synchronised level, bit2 its previous value
    assign ca_edge = pcr_q[0] ? (ca_sync_q[1] & ~ca_sync_q[2]) : (~ca_sync_q[1] & ca_sync_q[2]);
    assign cb_edge = pcr_q[4] ? (cb_sync_q[1] & ~cb_sync_q[2]) : (~cb_sync_q[1] & cb_sync_q[2]);

    assign t1_load    = wr & (reg_sel == REG_T1CH);
    assign t1_timeout = t1_armed_q & (t1_cnt_q == '0);
`ifdef VIA_TIMER2_EN
    assign t2_load    = wr & (reg_sel == REG_T2CH);
    assign t2_timeout = t2_armed_q & (t2_cnt_q == '0);
`endif

    always_comb begin
        ora_d       = ora_q;
        orb_d       = orb_q;
        ddra_d      = ddra_q;
        ddrb_d      = ddrb_q;
        acr_d       = acr_q;
        pcr_d       = pcr_q;
        ier_d       = ier_q;
        t1_lat_d    = t1_lat_q;
        t1_cnt_d    = t1_cnt_q;
        t1_armed_d  = t1_armed_q;
        t1_reload_d = 1'b0;
        ifr_set     = '0;
        ifr_clr     = '0;
        ca_sync_d   = {ca_sync_q[1:0], ca1};
        cb_sync_d   = {cb_sync_q[1:0], cb1};
`ifdef VIA_TIMER2_EN
        t2_lat_d    = t2_lat_q;
        t2_cnt_d    = t2_cnt_q;
        t2_armed_d  = t2_armed_q;
`endif

        if (wr) begin
            case (reg_sel)
                REG_ORB:              orb_d  = bus.din;
                REG_ORA, REG_ORA_NH:  ora_d  = bus.din;
                REG_DDRB:             ddrb_d = bus.din;
                REG_DDRA:             ddra_d = bus.din;
                REG_T1CL, REG_T1LL:   t1_lat_d[7:0]  = bus.din;
                REG_T1CH, REG_T1LH:   t1_lat_d[15:8] = bus.din;
`ifdef VIA_TIMER2_EN
                REG_T2CL:             t2_lat_d = bus.din;
`endif
                REG_ACR:              acr_d  = bus.din;
                REG_PCR:              pcr_d  = bus.din;
                REG_IFR:              ifr_clr = bus.din[6:0];
                REG_IER:              ier_d  = bus.din[7] ? (ier_q | bus.din[6:0])
                                                          : (ier_q & ~bus.din[6:0]);
                default: ;
            endcase
        end

        // Free-run timeout passes through 0xFFFF before reloading, giving N+2
        if (t1_load) begin
            t1_cnt_d   = {bus.din, t1_lat_q[7:0]};
            t1_armed_d = 1'b1;
        end else if (t1_reload_q) begin
            t1_cnt_d = t1_lat_q;
        end else begin
            t1_cnt_d = t1_cnt_q - 16'd1;
            if (t1_timeout) begin
                t1_armed_d  = acr_q[6];
                t1_reload_d = acr_q[6];
            end
        end

`ifdef VIA_TIMER2_EN
        if (t2_load) begin
            t2_cnt_d   = {bus.din, t2_lat_q};
            t2_armed_d = 1'b1;
        end else begin
            t2_cnt_d = t2_cnt_q - 16'd1;
            if (t2_timeout) t2_armed_d = 1'b0;
        end
        ifr_set[5]  = t2_timeout & ~t2_load;
        ifr_clr[5]  = ifr_clr[5] | (rd & (reg_sel == REG_T2CL)) | t2_load;
`endif

        ifr_set[1] = ca_edge;
        ifr_set[4] = cb_edge;
        ifr_set[6] = t1_timeout & ~t1_load;
        ifr_clr[1] = ifr_clr[1] | (bus.cs & (reg_sel == REG_ORA));
        ifr_clr[4] = ifr_clr[4] | (bus.cs & (reg_sel == REG_ORB));
        ifr_clr[6] = ifr_clr[6] | (rd & (reg_sel == REG_T1CL))
                                | (wr & (reg_sel == REG_T1LH)) | t1_load;
        // Set beats clear; a timer load suppresses its own set above
        ifr_d = (ifr_set | (ifr_q & ~ifr_clr)) & 7'b111_0010;
    end

    always_comb begin
        bus.dout = '0;
        case (reg_sel)
            REG_ORB:             bus.dout = (orb_q & ddrb_q) | (pb_in & ~ddrb_q);
            REG_ORA, REG_ORA_NH: bus.dout = pa_in;
            REG_DDRB:            bus.dout = ddrb_q;
            REG_DDRA:            bus.dout = ddra_q;
            REG_T1CL:            bus.dout = t1_cnt_q[7:0];
            REG_T1CH:            bus.dout = t1_cnt_q[15:8];
            REG_T1LL:            bus.dout = t1_lat_q[7:0];
            REG_T1LH:            bus.dout = t1_lat_q[15:8];
`ifdef VIA_TIMER2_EN
            REG_T2CL:            bus.dout = t2_cnt_q[7:0];
            REG_T2CH:            bus.dout = t2_cnt_q[15:8];
`endif
            REG_ACR:             bus.dout = acr_q;
            REG_PCR:             bus.dout = pcr_q;
            REG_IFR:             bus.dout = {|(ifr_q & ier_q), ifr_q};
            REG_IER:             bus.dout = {1'b1, ier_q};
            default:             bus.dout = '0;
        endcase
    end

    assign bus.irq_n = ~|(ifr_q & ier_q);
    assign pa_out    = ora_q;
    assign pb_out    = orb_q;
    assign pa_oe     = ddra_q;
    assign pb_oe     = ddrb_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ora_q       <= '0;
            orb_q       <= '0;
            ddra_q      <= '0;
            ddrb_q      <= '0;
            acr_q       <= '0;
            pcr_q       <= '0;
            ifr_q       <= '0;
            ier_q       <= '0;
            ca_sync_q   <= '0;
            cb_sync_q   <= '0;
            t1_cnt_q    <= '0;
            t1_lat_q    <= '0;
            t1_armed_q  <= 1'b0;
            t1_reload_q <= 1'b0;
`ifdef VIA_TIMER2_EN
            t2_cnt_q    <= '0;
            t2_lat_q    <= '0;
            t2_armed_q  <= 1'b0;
`endif
        end else begin
            ora_q       <= ora_d;
            orb_q       <= orb_d;
            ddra_q      <= ddra_d;
            ddrb_q      <= ddrb_d;
            acr_q       <= acr_d;
            pcr_q       <= pcr_d;
            ifr_q       <= ifr_d;
            ier_q       <= ier_d;
            ca_sync_q   <= ca_sync_d;
            cb_sync_q   <= cb_sync_d;
            t1_cnt_q    <= t1_cnt_d;
            t1_lat_q    <= t1_lat_d;
            t1_armed_q  <= t1_armed_d;
            t1_reload_q <= t1_reload_d;
`ifdef VIA_TIMER2_EN
            t2_cnt_q    <= t2_cnt_d;
            t2_lat_q    <= t2_lat_d;
            t2_armed_q  <= t2_armed_d;
`endif
        end
    end

endmodule

// File: tb/tb_via6522_lite.sv
// Bench for via6522_lite: directed register sequences, an event-time model of
// the VIA checked every cycle, plus literal expectations for key scenarios.
`timescale 1ns/1ps

module tb_via6522_lite;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] pa_in = '0, pb_in = '0;
    logic [7:0] pa_out, pb_out, pa_oe, pb_oe;
    logic       ca1 = 1'b0, cb1 = 1'b0;

    int errors = 0;
    int checks = 0;

    via6522_lite_if bus ();

    via6522_lite dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .pa_in   (pa_in),
        .pb_in   (pb_in),
        .pa_out  (pa_out),
        .pb_out  (pb_out),
        .pa_oe   (pa_oe),
        .pb_oe   (pb_oe),
        .ca1     (ca1),
        .cb1     (cb1)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    int         cyc = 0;
    logic [7:0] m_ora, m_orb, m_ddra, m_ddrb, m_acr, m_pcr, m_t1ll, m_t1lh, m_t2ll;
    logic [6:0] m_ifr, m_ier;
    int         t1_l, t1_n, t2_l, t2_n;
    bit         t1_live, t1_free, t2_live;
    logic [2:0] ca_h, cb_h;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeout happens N+1 edges after a load; free-run repeats every N+2 edges
    function automatic bit t_timeout(int c, int l, int n, bit live, bit free);
        int k;
        k = c - l;
        if (!live) return 1'b0;
        if (!free) return k == n + 1;
        return (k >= n + 1) && (((k - n - 1) % (n + 2)) == 0);
    endfunction

    function automatic logic [15:0] t_count(int c, int l, int n, bit free);
        int k, j;
        k = c - l;
        if (!free || k <= n) return 16'(n - k);
        j = (k - n - 1) % (n + 2);
        if (j == 0) return 16'hFFFF;
        return 16'(n - j + 1);
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] a);
        logic [15:0] c1, c2;
        c1 = t_count(cyc, t1_l, t1_n, t1_live && t1_free);
        c2 = t_count(cyc, t2_l, t2_n, 1'b0);
        case (a)
            4'h0:       return (m_orb & m_ddrb) | (pb_in & ~m_ddrb);
            4'h1, 4'hF: return pa_in;
            4'h2:       return m_ddrb;
            4'h3:       return m_ddra;
            4'h4:       return c1[7:0];
            4'h5:       return c1[15:8];
            4'h6:       return m_t1ll;
            4'h7:       return m_t1lh;
`ifdef VIA_TIMER2_EN
            4'h8:       return c2[7:0];
            4'h9:       return c2[15:8];
`endif
            4'hB:       return m_acr;
            4'hC:       return m_pcr;
            4'hD:       return {|(m_ifr & m_ier), m_ifr};
            4'hE:       return {1'b1, m_ier};
            default:    return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        logic       w, r, ld1, ld2;
        logic [3:0] a;
        logic [7:0] d;
        logic [6:0] set, clr;
        cyc++;
        if (!reset_n) begin
            {m_ora, m_orb, m_ddra, m_ddrb, m_acr, m_pcr, m_t1ll, m_t1lh, m_t2ll} = '0;
            m_ifr = '0; m_ier = '0;
            t1_l = cyc; t1_n = 0; t1_live = 0; t1_free = 0;
            t2_l = cyc; t2_n = 0; t2_live = 0;
            ca_h = '0; cb_h = '0;
        end else begin
            w = bus.cs && !bus.rnw; r = bus.cs && bus.rnw; a = bus.addr; d = bus.din;
            set = '0; clr = '0;
            if (m_pcr[0] ? (ca_h[1] && !ca_h[2]) : (!ca_h[1] && ca_h[2])) set[1] = 1'b1;
            if (m_pcr[4] ? (cb_h[1] && !cb_h[2]) : (!cb_h[1] && cb_h[2])) set[4] = 1'b1;
            ld1 = w && a == 4'h5;
            ld2 = 1'b0;
            if (t_timeout(cyc, t1_l, t1_n, t1_live, t1_free) && !ld1) set[6] = 1'b1;
`ifdef VIA_TIMER2_EN
            ld2 = w && a == 4'h9;
            if (t_timeout(cyc, t2_l, t2_n, t2_live, 1'b0) && !ld2) set[5] = 1'b1;
            if ((r && a == 4'h8) || ld2) clr[5] = 1'b1;
`endif
            if (bus.cs && a == 4'h1) clr[1] = 1'b1;
            if (bus.cs && a == 4'h0) clr[4] = 1'b1;
            if ((r && a == 4'h4) || (w && (a == 4'h5 || a == 4'h7))) clr[6] = 1'b1;
            if (w && a == 4'hD) clr = clr | d[6:0];
            m_ifr = set | (m_ifr & ~clr);
            if (w) begin
                case (a)
                    4'h0: m_orb = d;
                    4'h1, 4'hF: m_ora = d;
                    4'h2: m_ddrb = d;
                    4'h3: m_ddra = d;
                    4'h4, 4'h6: m_t1ll = d;
                    4'h5, 4'h7: m_t1lh = d;
                    4'h8: m_t2ll = d;
                    4'hB: m_acr = d;
                    4'hC: m_pcr = d;
                    4'hE: m_ier = d[7] ? (m_ier | d[6:0]) : (m_ier & ~d[6:0]);
                    default: ;
                endcase
            end
            if (ld1) begin
                t1_l = cyc; t1_n = int'({d, m_t1ll}); t1_live = 1; t1_free = m_acr[6];
            end
            if (ld2) begin
                t2_l = cyc; t2_n = int'({d, m_t2ll}); t2_live = 1;
            end
            ca_h = {ca_h[1:0], ca1};
            cb_h = {cb_h[1:0], cb1};
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (cyc > 0) begin
            chk("irq_n",  16'(bus.irq_n), 16'(~|(m_ifr & m_ier)));
            chk("dout",   16'(bus.dout),  16'(model_read(bus.addr)));
            chk("pa_out", 16'(pa_out),    16'(m_ora));
            chk("pb_out", 16'(pb_out),    16'(m_orb));
            chk("pa_oe",  16'(pa_oe),     16'(m_ddra));
            chk("pb_oe",  16'(pb_oe),     16'(m_ddrb));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.rnw = 1'b0; bus.addr = a; bus.din = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.rnw = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        @(negedge clk);
        bus.cs = 1'b1; bus.rnw = 1'b1; bus.addr = a;
        #1 v = bus.dout;
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
    endtask

    // Edges until irq_n is seen low; limit+1 when it never falls
    task automatic wait_irq(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.irq_n) return;
        end
        n = limit + 1;
    endtask

    initial begin
        logic [7:0] v;
        int         n, t_prev, lows;
        bus.cs = 1'b0; bus.rnw = 1'b1; bus.addr = '0; bus.din = '0;
        idle(3);
        reset_n = 1'b1;

        rd(4'hE, v);  chk("ier_after_reset", 16'(v), 16'h0080);
        rd(4'hD, v);  chk("ifr_after_reset", 16'(v), 16'h0000);
        chk("irq_after_reset", 16'(bus.irq_n), 16'h0001);

        // Port B mixes output latch and pins by DDR; port A reads pins
        wr(4'h2, 8'h0F);
        wr(4'h0, 8'hA5);
        pb_in = 8'h3C;
        rd(4'h0, v);  chk("irb_mix", 16'(v), 16'h0035);
        chk("pb_oe", 16'(pb_oe), 16'h000F);
        wr(4'h3, 8'hF0);
        wr(4'h1, 8'h5A);
        pa_in = 8'h77;
        rd(4'h1, v);  chk("ira_pins", 16'(v), 16'h0077);
        chk("pa_out", 16'(pa_out), 16'h005A);
        pa_in = '0; pb_in = '0;

        // T1 one-shot: 6 clocks for N=5, flag cleared by counter-low read
        do_reset();
        wr(4'hE, 8'hC0);
        wr(4'hB, 8'h00);
        wr(4'h4, 8'h05);
        wr(4'h5, 8'h00);
        wait_irq(20, n);  chk("t1_oneshot_latency", 16'(n), 16'd6);
        rd(4'h4, v);
        chk("irq_after_t1l_read", 16'(bus.irq_n), 16'h0001);
        bus.addr = 4'hD;
        lows = 0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            if (!bus.irq_n) lows++;
        end
        chk("t1_no_second_irq", 16'(lows), 16'd0);

        // T1 free-run N=3: first flag after 4, then every 5
        do_reset();
        wr(4'hB, 8'h40);
        wr(4'hE, 8'hC0);
        wr(4'h4, 8'h03);
        wr(4'h5, 8'h00);
        t_prev = cyc;
        for (int i = 0; i < 4; i++) begin
            wait_irq(12, n);
            chk("t1_free_period", 16'(cyc - t_prev), (i == 0) ? 16'd4 : 16'd5);
            t_prev = cyc;
            wr(4'hD, 8'h40);
        end

        // Load in the timeout cycle wins; read-clear in the timeout cycle loses
        do_reset();
        wr(4'hE, 8'hC0);
        wr(4'h4, 8'h02);
        wr(4'h5, 8'h00);
        idle(1);
        wr(4'h5, 8'h00);
        chk("load_beats_timeout", 16'(bus.irq_n), 16'h0001);
        idle(1);
        rd(4'h4, v);
        chk("t1_count_at_timeout", 16'(v), 16'h0000);
        chk("set_beats_read_clear", 16'(bus.irq_n), 16'h0000);

        // CA1 rising edge, cleared by reg 1 access; falling ignored
        do_reset();
        wr(4'hC, 8'h01);
        wr(4'hE, 8'h82);
        @(negedge clk);
        ca1 = 1'b1;
        wait_irq(6, n);  chk("ca1_latency", 16'(n), 16'd3);
        rd(4'hD, v);  chk("ifr_ca1", 16'(v), 16'h0082);
        rd(4'h1, v);
        rd(4'hD, v);  chk("ifr_ca1_cleared", 16'(v), 16'h0000);
        ca1 = 1'b0;
        idle(6);
        rd(4'hD, v);  chk("ca1_falling_ignored", 16'(v), 16'h0000);
        // CB1 with PCR[4]=0 flags only the falling edge; reg 0 read clears it
        wr(4'hE, 8'h90);
        cb1 = 1'b1;
        idle(6);
        rd(4'hD, v);  chk("cb1_rising_ignored", 16'(v), 16'h0000);
        cb1 = 1'b0;
        idle(6);
        rd(4'hD, v);  chk("cb1_falling", 16'(v), 16'h0090);
        rd(4'h0, v);
        rd(4'hD, v);  chk("cb1_cleared", 16'(v), 16'h0000);

        // T2 one-shot N=0x10
        do_reset();
        wr(4'hE, 8'hA0);
        wr(4'h8, 8'h10);
        wr(4'h9, 8'h00);
`ifdef VIA_TIMER2_EN
        wait_irq(30, n);  chk("t2_latency", 16'(n), 16'd17);
        rd(4'hD, v);  chk("ifr_t2", 16'(v), 16'h00A0);
        rd(4'h8, v);
        rd(4'hD, v);  chk("ifr_t2_cleared", 16'(v), 16'h0000);
`else
        idle(30);
        rd(4'hD, v);  chk("ifr_no_t2", 16'(v), 16'h0000);
        rd(4'h8, v);  chk("t2_absent_read", 16'(v), 16'h0000);
`endif

        // Reset mid T1 countdown: no flag, everything back to zero
        do_reset();
        wr(4'h3, 8'hFF);
        wr(4'h1, 8'h12);
        wr(4'hE, 8'hC0);
        wr(4'hB, 8'h00);
        wr(4'h4, 8'h20);
        wr(4'h5, 8'h00);
        idle(10);
        reset_n = 1'b0;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (!bus.irq_n) lows++;
        end
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            bus.addr = 4'(a);
            #1 chk("reg_in_reset", 16'(bus.dout), (a == 14) ? 16'h0080 : 16'h0000);
        end
        chk("pa_oe_in_reset", 16'(pa_oe), 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (!bus.irq_n) lows++;
        end
        chk("no_irq_after_reset_abort", 16'(lows), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
